dmem_store_buffer: RTL
======================

Name: dmem_store_buffer

Overview:
Posted-write buffer between the CPU data port and the single-port data memory. CPU stores are accepted into a small in-order FIFO and retire to memory when the memory port is idle and ready. CPU loads are served with zero latency, either from the youngest matching buffered store or from memory. This lets the core run stores without waiting on a slow or back-pressuring memory.

Parameters:
DEPTH, 4, number of buffered store entries; power of two, ≥2.
ADDR_W, 32, address width; word-aligned addresses only, full-word stores.
DATA_W, 32, data width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous active-high reset.
cpu_addr  in  ADDR_W  CPU load/store address.
cpu_wdata  in  DATA_W  CPU store data.
cpu_we  in  1  CPU store request.
cpu_re  in  1  CPU load request.
cpu_rdata  out  DATA_W  load data; combinational.
cpu_stall  out  1  CPU must hold the current access and retry; combinational.
mem_addr  out  ADDR_W  memory address, shared by read and write.
mem_wdata  out  DATA_W  memory write data.
mem_we  out  1  memory write strobe; write commits at the clk edge.
mem_rdata  in  DATA_W  memory read data; combinational from mem_addr.
mem_ready  in  1  memory can accept a write this cycle.
sb_empty  out  1  buffer holds no entries; used for fence and end-of-test.
sb_count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage: circular FIFO of {addr, data}.
  - head and tail pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Drain condition: drain = !empty && mem_ready && (!cpu_re || full).
  - When drain=1: mem_we=1, mem_addr=head.addr, mem_wdata=head.data.
  - The head pops at the same edge.
  - Exactly one entry retires per cycle, in program order.
- Read path:
  - When drain=0: mem_we=0, mem_addr=cpu_addr.
  - mem_wdata is don't-care; drive head.data.
- Stall: cpu_stall = full && (cpu_we || cpu_re).
  - While full, every CPU access stalls and draining has priority over loads.
  - Once count<DEPTH, the stall drops combinationally.
  - Full with mem_ready=0 stalls indefinitely until memory becomes ready.
- Enqueue: cpu_we && !full pushes {cpu_addr, cpu_wdata} at the tail at the edge.
  - Enqueue and drain in the same cycle leave count unchanged.
  - Pointers still advance on both sides.
- Load forwarding: when cpu_re && !cpu_stall, cpu_rdata = data of the youngest valid entry whose addr == cpu_addr, else mem_rdata.
  - Search order is tail-1 back to head.
  - The comparison is on the full address; there are no partial or byte matches.
- When cpu_re=0, cpu_rdata is don't-care; drive mem_rdata.
- cpu_we && cpu_re in the same cycle is illegal. The block treats it as a store plus a load and does not check it; the load sees pre-enqueue contents.
- Same-address stores: both entries are kept and drained oldest first, so memory finishes holding the youngest value. Forwarding always returns the youngest value.
- Reset (synchronous):
  - count, head and tail go to 0; all entries are discarded, including any mid-drain.
  - Outputs after reset: mem_we=0, cpu_stall=0, sb_empty=1, sb_count=0.
  - While rst=1, mem_we is forced to 0.
- Latency:
  - A store is visible to loads in the cycle after acceptance.
  - With mem_ready=1 and no loads, a store reaches memory at the next edge after acceptance, which is the earliest possible.

Test Plan:
1. Reset, mem_ready=1, store 0x100←4, then idle -> next cycle mem_we=1, mem_addr=0x100, mem_wdata=4; after that edge sb_empty=1 and mem word 64 holds 4.
2. mem_ready=0; store 0x104←5; load 0x104 -> cpu_rdata=5 while memory still holds 0; load 0x108 -> cpu_rdata=mem_rdata; sb_count=1.
3. mem_ready=0; store 0x108←3 then 0x108←7; load 0x108 -> 7; raise mem_ready -> two mem_we pulses carrying 3 then 7; final mem word 66 holds 7.
4. DEPTH=4, mem_ready=0; four stores fill the buffer -> sb_count=4; a fifth store and a load both see cpu_stall=1; raise mem_ready for one cycle -> one drain, sb_count=3, cpu_stall drops, fifth store accepted.
5. Three entries buffered, mem_ready=0; assert rst for one cycle with mem_ready=1 -> no mem_we at any time; sb_count=0, sb_empty=1; memory unchanged.
6. Buffer empty; load 0x10C with mem_rdata=2 -> cpu_rdata=2, cpu_stall=0, mem_addr=0x10C, mem_we=0.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the CPU data port and a single-port data memory.
// In-order FIFO of {addr, data}; loads forward from the youngest matching entry.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    input  logic                       cpu_we,
    input  logic                       cpu_re,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_stall,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ready,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH+1)-1:0] sb_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_drain;
    logic              w_push;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]  w_idx;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // Loads win the memory port unless the buffer is full; reset suppresses any write.
    assign w_drain = !rst && !w_empty && mem_ready && (!cpu_re || w_full);
    assign w_push  = cpu_we && !w_full;

    assign cpu_stall = w_full && (cpu_we || cpu_re);
    assign mem_we    = w_drain;
    assign mem_addr  = w_drain ? r_addr[r_head] : cpu_addr;
    assign mem_wdata = r_data[r_head];
    assign sb_empty  = w_empty;
    assign sb_count  = r_count;

    // Walk oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = r_data[r_head];
        w_idx      = r_head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == cpu_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign cpu_rdata = (cpu_re && !cpu_stall && w_fwd_hit) ? w_fwd_data : mem_rdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= cpu_addr;
            r_data[r_tail] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
